placement_cost_eval: RTL and testbench

//  Post-placement cost evaluator, downstream of the random placer. After the placer's out goes high,
//  it walks the edge lists (ea/eb ROMs) and reads node coordinates from the pos_X/pos_Y RAMs.

---
 rtl/placement_pkg.sv | 23 ++
 rtl/placement_cost_eval_edge_cost_calc.sv | 36 +++
 rtl/placement_cost_eval.sv | 201 ++++++++++++++++++++
 tb/tb_placement_cost_eval.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/placement_pkg.sv
// Shared definitions for the post-placement cost evaluator: FSM encoding,
// the unplaced-coordinate marker and default sizing.
package placement_pkg;

    localparam int N_EDGE_DEF  = 88;
    localparam int W_DEF       = 32;
    localparam int EDGE_AW_DEF = 10;
    localparam int POS_AW_DEF  = 7;

    // A coordinate equal to this value means the placer never placed the node.
    localparam int UNPLACED = -1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EDGE = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_ABS  = 3'd4,
        S_ACC  = 3'd5,
        S_FIN  = 3'd6
    } state_t;

endpackage

// File: rtl/placement_cost_eval_edge_cost_calc.sv
// Combinational per-edge cost: |dx|, |dy|, Manhattan length, 1-hop length and
// the unplaced-endpoint flag. Zero latency, no flow control.
module edge_cost_calc
    import placement_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    output logic [W-1:0] dx,
    output logic [W-1:0] dy,
    output logic [W-1:0] len,
    output logic [W-1:0] hop,
    output logic         skip
);

    localparam logic [W-1:0] UNPLACED_W = W'(UNPLACED);

    logic [W-1:0] diff_x;
    logic [W-1:0] diff_y;

    always_comb begin
        diff_x = ax - bx;
        diff_y = ay - by;
        dx     = diff_x[W-1] ? -diff_x : diff_x;
        dy     = diff_y[W-1] ? -diff_y : diff_y;
        len    = dx + dy;
        // ceil(d/2) as (d>>1) plus the dropped low bit
        hop    = (dx >> 1) + W'(dx[0]) + (dy >> 1) + W'(dy[0]);
        skip   = (ax == UNPLACED_W) || (ay == UNPLACED_W) ||
                 (bx == UNPLACED_W) || (by == UNPLACED_W);
    end

endmodule

// File: rtl/placement_cost_eval.sv
// Walks the edge ROMs, fetches both endpoint positions and accumulates wirelength,
// 1-hop wirelength, longest edge and an unplaced flag; 5 cycles/edge, done at 5*N_EDGE+2.
module placement_cost_eval
    import placement_pkg::*;
#(
    parameter int N_EDGE  = N_EDGE_DEF,
    parameter int W       = W_DEF,
    parameter int EDGE_AW = EDGE_AW_DEF,
    parameter int POS_AW  = POS_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               edge_re,
    output logic [EDGE_AW-1:0] edge_addr,
    input  logic [W-1:0]       edge_a,
    input  logic [W-1:0]       edge_b,
    output logic               pos_re,
    output logic [POS_AW-1:0]  pos_addr,
    input  logic [W-1:0]       pos_x,
    input  logic [W-1:0]       pos_y,
    output logic [W-1:0]       sum,
    output logic [W-1:0]       sum_1hop,
    output logic [W-1:0]       max_len,
    output logic               unplaced
);

    localparam logic [EDGE_AW-1:0] LAST_IDX = EDGE_AW'(N_EDGE - 1);

    state_t              state_q, state_d;
    logic [EDGE_AW-1:0]  i_q, i_d;
    logic [POS_AW-1:0]   b_id_q, b_id_d;
    logic [W-1:0]        ax_q, ax_d;
    logic [W-1:0]        ay_q, ay_d;
    logic [W-1:0]        dx_q, dx_d;
    logic [W-1:0]        dy_q, dy_d;
    logic [W-1:0]        len_q, len_d;
    logic [W-1:0]        hop_q, hop_d;
    logic                skip_q, skip_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W-1:0]        sum_q, sum_d;
    logic [W-1:0]        sum_1hop_q, sum_1hop_d;
    logic [W-1:0]        max_len_q, max_len_d;
    logic                unplaced_q, unplaced_d;

    logic [W-1:0]        calc_dx, calc_dy, calc_len, calc_hop;
    logic                calc_skip;

    // Node ids occupy only the low POS_AW bits of the edge ROM words.
    logic                unused_edge_hi;
    assign unused_edge_hi = ^{edge_a[W-1:POS_AW], edge_b[W-1:POS_AW]};

    edge_cost_calc #(
        .W (W)
    ) u_calc (
        .ax   (ax_q),
        .ay   (ay_q),
        .bx   (pos_x),
        .by   (pos_y),
        .dx   (calc_dx),
        .dy   (calc_dy),
        .len  (calc_len),
        .hop  (calc_hop),
        .skip (calc_skip)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        b_id_d     = b_id_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        len_d      = len_q;
        hop_d      = hop_q;
        skip_d     = skip_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sum_d      = sum_q;
        sum_1hop_d = sum_1hop_q;
        max_len_d  = max_len_q;
        unplaced_d = unplaced_q;
        edge_re    = 1'b0;
        pos_re     = 1'b0;
        pos_addr   = '0;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high in the done cycle, so a start there is ignored.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    busy_d     = 1'b1;
                    sum_d      = '0;
                    sum_1hop_d = '0;
                    max_len_d  = '0;
                    unplaced_d = 1'b0;
                    i_d        = '0;
                    state_d    = (N_EDGE == 0) ? S_FIN : S_EDGE;
                end
            end
            S_EDGE: begin
                edge_re = 1'b1;
                state_d = S_RDA;
            end
            S_RDA: begin
                b_id_d   = edge_b[POS_AW-1:0];
                pos_re   = 1'b1;
                pos_addr = edge_a[POS_AW-1:0];
                state_d  = S_RDB;
            end
            S_RDB: begin
                ax_d     = pos_x;
                ay_d     = pos_y;
                pos_re   = 1'b1;
                pos_addr = b_id_q;
                state_d  = S_ABS;
            end
            S_ABS: begin
                dx_d    = calc_dx;
                dy_d    = calc_dy;
                len_d   = calc_len;
                hop_d   = calc_hop;
                skip_d  = calc_skip;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (skip_q) begin
                    unplaced_d = 1'b1;
                end else begin
                    sum_d      = sum_q + dx_q + dy_q - W'(1);
                    sum_1hop_d = sum_1hop_q + hop_q - W'(1);
                    if ($signed(len_q) > $signed(max_len_q)) begin
                        max_len_d = len_q;
                    end
                end
                i_d     = i_q + EDGE_AW'(1);
                state_d = (i_q == LAST_IDX) ? S_FIN : S_EDGE;
            end
            S_FIN: begin
                // Registered outputs: done and the final busy cycle appear next cycle.
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            b_id_q     <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            len_q      <= '0;
            hop_q      <= '0;
            skip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            sum_1hop_q <= '0;
            max_len_q  <= '0;
            unplaced_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            b_id_q     <= b_id_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            len_q      <= len_d;
            hop_q      <= hop_d;
            skip_q     <= skip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            sum_1hop_q <= sum_1hop_d;
            max_len_q  <= max_len_d;
            unplaced_q <= unplaced_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign edge_addr = i_q;
    assign sum       = sum_q;
    assign sum_1hop  = sum_1hop_q;
    assign max_len   = max_len_q;
    assign unplaced  = unplaced_q;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Bench for placement_cost_eval: three instances (1, 2 and 88 edges) sharing
// 1-cycle-latency ROM/RAM contents, checked every cycle against a behavioural model.
module tb_placement_cost_eval;

    localparam int W   = 32;
    localparam int EAW = 10;
    localparam int PAW = 7;
    localparam int ND  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int ea_mem [0:1023];
    int eb_mem [0:1023];
    int px_mem [0:127];
    int py_mem [0:127];

    logic [ND-1:0]  start, busy, done, edge_re, pos_re, unp;
    logic [EAW-1:0] edge_addr [ND];
    logic [PAW-1:0] pos_addr  [ND];
    logic [W-1:0]   sum [ND];
    logic [W-1:0]   hop [ND];
    logic [W-1:0]   mx  [ND];

    int tests;
    int fails;

    function automatic int ne(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 88);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [W-1:0] ea_q, eb_q, px_q, py_q;

        always @(posedge clk) begin
            if (edge_re[g]) begin
                ea_q <= ea_mem[edge_addr[g]];
                eb_q <= eb_mem[edge_addr[g]];
            end
            if (pos_re[g]) begin
                px_q <= px_mem[pos_addr[g]];
                py_q <= py_mem[pos_addr[g]];
            end
        end

        placement_cost_eval #(
            .N_EDGE  ((g == 0) ? 1 : ((g == 1) ? 2 : 88)),
            .W       (W),
            .EDGE_AW (EAW),
            .POS_AW  (PAW)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .edge_re   (edge_re[g]),
            .edge_addr (edge_addr[g]),
            .edge_a    (ea_q),
            .edge_b    (eb_q),
            .pos_re    (pos_re[g]),
            .pos_addr  (pos_addr[g]),
            .pos_x     (px_q),
            .pos_y     (py_q),
            .sum       (sum[g]),
            .sum_1hop  (hop[g]),
            .max_len   (mx[g]),
            .unplaced  (unp[g])
        );
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", nm, k, cyc, act, exp);
        end
    endtask

    // Reference: plain walk over the edge list using the cost rules.
    function automatic void model(input int n, output int s, output int h,
                                  output int m, output bit u);
        s = 0; h = 0; m = 0; u = 0;
        for (int e = 0; e < n; e++) begin
            int a, b, dx, dy;
            a = ea_mem[e] & 127;
            b = eb_mem[e] & 127;
            if (px_mem[a] == -1 || py_mem[a] == -1 || px_mem[b] == -1 || py_mem[b] == -1) begin
                u = 1;
            end else begin
                dx = px_mem[a] - px_mem[b];
                dy = py_mem[a] - py_mem[b];
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                s += dx + dy - 1;
                h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > m) m = dx + dy;
            end
        end
    endfunction

    bit act  [ND];
    int st_c [ND];
    int hs [ND];
    int hh [ND];
    int hm [ND];
    bit hu [ND];
    int done_cyc [ND];
    int ec, pc, eidx;

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (done[k]) done_cyc[k] = cyc;
        end
    end

    // Per-cycle compare of every instance against the model's expectations.
    always @(negedge clk) begin
        int el, lat, s, h, m;
        bit u;
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                act[k] = 0; hs[k] = 0; hh[k] = 0; hm[k] = 0; hu[k] = 0;
                if (k == 2) begin ec = 0; pc = 0; eidx = 0; end
                chk("rst_busy", k, busy[k], 0);
                chk("rst_done", k, done[k], 0);
                chk("rst_sum", k, sum[k], 0);
                chk("rst_hop", k, hop[k], 0);
                chk("rst_max", k, mx[k], 0);
                chk("rst_unplaced", k, unp[k], 0);
                chk("rst_edge_re", k, edge_re[k], 0);
                chk("rst_pos_re", k, pos_re[k], 0);
                chk("rst_edge_addr", k, edge_addr[k], 0);
                chk("rst_pos_addr", k, pos_addr[k], 0);
            end else if (act[k]) begin
                el  = cyc - st_c[k];
                lat = 5 * ne(k) + 2;
                chk("busy", k, busy[k], (el >= 1) ? 1 : 0);
                chk("done", k, done[k], (el == lat) ? 1 : 0);
                if (k == 2) begin
                    if (edge_re[2]) begin
                        chk("edge_addr_seq", 2, edge_addr[2], eidx);
                        eidx++;
                        ec++;
                    end
                    if (pos_re[2]) pc++;
                end
                if (el == lat) begin
                    model(ne(k), s, h, m, u);
                    chk("sum", k, sum[k], s);
                    chk("sum_1hop", k, hop[k], h);
                    chk("max_len", k, mx[k], m);
                    chk("unplaced", k, unp[k], u);
                    if (k == 2) begin
                        chk("edge_re_count", 2, ec, 88);
                        chk("pos_re_count", 2, pc, 176);
                    end
                    hs[k] = s; hh[k] = h; hm[k] = m; hu[k] = u;
                    act[k] = 0;
                end
            end else begin
                chk("idle_busy", k, busy[k], 0);
                chk("idle_done", k, done[k], 0);
                chk("hold_sum", k, sum[k], hs[k]);
                chk("hold_hop", k, hop[k], hh[k]);
                chk("hold_max", k, mx[k], hm[k]);
                chk("hold_unplaced", k, unp[k], hu[k]);
            end
        end
    end

    task automatic start_run(input int k);
        @(posedge clk); #1;
        start[k]    = 1'b1;
        st_c[k]     = cyc;
        act[k]      = 1;
        done_cyc[k] = -1;
        if (k == 2) begin ec = 0; pc = 0; eidx = 0; end
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int budget;
        budget = 5 * ne(k) + 20;
        while (act[k] && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("done_timeout", k, act[k], 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input bit allow_unplaced);
        for (int e = 0; e < 88; e++) begin
            ea_mem[e] = int'($urandom_range(0, 127));
            eb_mem[e] = int'($urandom_range(0, 127));
        end
        for (int n = 0; n < 128; n++) begin
            px_mem[n] = int'($urandom_range(0, 400)) - 200;
            py_mem[n] = int'($urandom_range(0, 400)) - 200;
            if (allow_unplaced && $urandom_range(0, 39) == 0) px_mem[n] = -1;
            if (allow_unplaced && $urandom_range(0, 39) == 0) py_mem[n] = -1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, h, m;
        bit u;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 128; i++) begin px_mem[i] = 0; py_mem[i] = 0; end
        for (int i = 0; i < 1024; i++) begin ea_mem[i] = 0; eb_mem[i] = 0; end
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        // T1: single edge (0,0)-(3,2)
        ea_mem[0] = 0; eb_mem[0] = 1;
        px_mem[0] = 0; py_mem[0] = 0; px_mem[1] = 3; py_mem[1] = 2;
        model(1, s, h, m, u);
        chk("model_t1_sum", 0, s, 4);
        chk("model_t1_hop", 0, h, 2);
        chk("model_t1_max", 0, m, 5);
        start_run(0);
        wait_done(0);
        chk("t1_sum", 0, sum[0], 4);
        chk("t1_hop", 0, hop[0], 2);
        chk("t1_max", 0, mx[0], 5);
        chk("t1_unplaced", 0, unp[0], 0);
        chk("t1_latency", 0, done_cyc[0] - st_c[0], 7);

        // T2: two edges over (1,1),(1,2),(4,2)
        ea_mem[1] = 1; eb_mem[1] = 2;
        px_mem[0] = 1; py_mem[0] = 1; px_mem[1] = 1; py_mem[1] = 2;
        px_mem[2] = 4; py_mem[2] = 2;
        model(2, s, h, m, u);
        chk("model_t2_sum", 1, s, 2);
        chk("model_t2_hop", 1, h, 1);
        start_run(1);
        wait_done(1);
        chk("t2_sum", 1, sum[1], 2);
        chk("t2_hop", 1, hop[1], 1);
        chk("t2_max", 1, mx[1], 3);
        chk("t2_latency", 1, done_cyc[1] - st_c[1], 12);

        // T3: unplaced endpoint on edge 0, valid edge 0->2 of length 2
        ea_mem[1] = 0; eb_mem[1] = 2;
        px_mem[0] = 0;  py_mem[0] = 0;
        px_mem[1] = -1; py_mem[1] = 5;
        px_mem[2] = 2;  py_mem[2] = 0;
        model(2, s, h, m, u);
        chk("model_t3_unplaced", 1, u, 1);
        start_run(1);
        wait_done(1);
        chk("t3_unplaced", 1, unp[1], 1);
        chk("t3_sum", 1, sum[1], 1);
        chk("t3_hop", 1, hop[1], 0);
        chk("t3_max", 1, mx[1], 2);

        // T4: reset 10 cycles into a full run, then a clean run
        fill_random(1'b1);
        start_run(2);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_abort_busy", 2, busy[2], 0);
        chk("t4_abort_sum", 2, sum[2], 0);
        chk("t4_abort_max", 2, mx[2], 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("t4_no_done", 2, done_cyc[2], -1);
        start_run(2);
        wait_done(2);
        chk("t4_latency", 2, done_cyc[2] - st_c[2], 442);

        // T5: start while busy is ignored; hold after done; restart recomputes
        fill_random(1'b0);
        start_run(2);
        repeat (50) @(posedge clk);
        #1 start[2] = 1'b1;
        @(posedge clk);
        #1 start[2] = 1'b0;
        wait_done(2);
        chk("t5_latency", 2, done_cyc[2] - st_c[2], 442);
        repeat (20) @(posedge clk);
        start_run(2);
        wait_done(2);

        // Extra random pass, memory changed while idle first
        fill_random(1'b1);
        repeat (10) @(posedge clk);
        start_run(2);
        wait_done(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
